interlayer_collect: RTL and testbench
=====================================

Name: interlayer_collect

Overview:
- Synchronous collector between two neuron layers.
- Four lanes each deliver an 8-bit activation with a ready strobe. The block registers each value when its strobe is high and tracks which lanes have delivered in the current round.
- It raises ready_out once all four lanes have delivered, which signals the next layer that out1..out4 are a coherent set.
- `new` from the input layer starts a fresh round.

Parameters:
- WIDTH, 8, bit width of each lane value (in*/out*).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- new  input  1  start-of-round strobe; clears the delivered flags.
- in1..in4  input  WIDTH each  lane data.
- ready1..ready4  input  1 each  lane capture strobe; in_k is sampled when ready_k=1.
- out1..out4  output  WIDTH each  registered lane values.
- ready_out  output  1  high while all four lanes have delivered in the current round.

Behaviour:
- Reset (rst=1 at rising clk edge, synchronous):
  - out1..out4 = 0, all four delivered flags = 0, ready_out = 0.
  - rst has priority over new and all ready_k.
- Capture:
  - If ready_k=1 at a rising edge, out_k <= in_k. The value is visible the cycle after, so latency is 1.
  - If ready_k=0, out_k holds its value.
  - Lanes are independent. Any subset may strobe in the same cycle.
- Delivered flag per lane (done_k):
  - Set when lane k captures.
  - Cleared by new or rst.
  - If new=1 and ready_k=1 in the same cycle, done_k ends at 1: the capture counts toward the new round.
  - new=1 alone clears all flags and leaves out1..out4 unchanged.
- ready_out:
  - Registered output.
  - ready_out = 1 in the cycle after done_1..4 all become 1.
  - Stays 1 (level, not a pulse) until new or rst clears the flags; falls in the cycle after that clearing edge.
- Repeat strobes:
  - A repeated ready_k in the same round overwrites out_k; ready_out is unaffected.
  - Exception: the optional feature below changes this.
- Boundary cases:
  - All four ready_k high in one cycle → ready_out = 1 the next cycle.
  - new and the last missing ready in the same cycle: the flags reset first, then only that lane's flag is set, so ready_out stays 0.
  - new held high continuously: only lanes strobing in the current cycle count, so ready_out rises only if all four strobe together.
  - X-free: all state is reset and no combinational path exists from inputs to outputs.

Optional Feature:
- Macro: INTERLAYER_HOLD_EN.
- Defined: the first capture per lane per round wins. While done_k=1, ready_k is ignored and out_k holds until new or rst. A simultaneous new + ready_k still captures.
- Undefined: every ready_k overwrites out_k, with last-write-wins as described above.

Decomposition:
- Shared package interlayer_pkg:
  - localparam NUM_LANES = 4.
  - Default WIDTH = 8.
  - typedef lane_t = logic [WIDTH-1:0].
- Natural sub-module lane_capture:
  - One lane: data register with enable, plus its done flag and hold logic.
  - Instantiated four times.
  - Top-level does the AND-reduce of done flags and the ready_out register.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in*=0xFF and ready*=1 → out1..4 = 0x00, ready_out = 0.
- Staggered delivery:
  - After a new pulse, ready1 with in1=0x11, then ready2/0x22, ready3/0x33, ready4/0x44 on successive cycles.
  - → outs = 11/22/33/44; ready_out = 0 until the cycle after ready4, then 1 and held.
- Round restart: with ready_out = 1, pulse new → ready_out = 0 next cycle; outs still 11/22/33/44.
- Simultaneous new + ready3 (in3=0x5A) → out3 = 0x5A, only done3 set, ready_out = 0; then ready1/2/4 → ready_out = 1.
- Overwrite:
  - ready2 with 0x10, then ready2 with 0x20 in the same round.
  - → out2 = 0x20 without INTERLAYER_HOLD_EN; 0x10 with it.
- Reset mid-round: two lanes delivered, then rst=1 → flags clear, outs = 0. Two further strobes → ready_out stays 0.

Source files
------------

// File: rtl/interlayer_pkg.sv
// Shared definitions for the interlayer collector: lane count, default lane
// width and the lane value type.
package interlayer_pkg;
    localparam int NUM_LANES     = 4;
    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] lane_t;
endpackage

// File: rtl/interlayer_collect_lane_capture.sv
// One collector lane: data register with capture enable plus its delivered
// flag for the current round. done_next is exported so the top can register
// ready_out from the flag values being written on this edge.
// Optional build macro: INTERLAYER_HOLD_EN (first capture per round wins).
module lane_capture
    import interlayer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_round,
    input  logic             strobe,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             done_next
);

    logic done;
    logic cap_en;

`ifdef INTERLAYER_HOLD_EN
    // Once delivered, the lane is frozen until a new round; a strobe that
    // coincides with new_round belongs to the new round and still captures.
    assign cap_en = strobe & (~done | new_round);
`else
    assign cap_en = strobe;
`endif

    // Flag update: new_round clears first, then this cycle's strobe sets it.
    always_comb begin
        done_next = done;
        if (new_round) begin
            done_next = strobe;
        end else if (strobe) begin
            done_next = 1'b1;
        end
    end

    // Data register and delivered flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            done <= 1'b0;
        end else begin
            if (cap_en) begin
                dout <= din;
            end
            done <= done_next;
        end
    end

endmodule

// File: rtl/interlayer_collect.sv
// Four-lane activation collector between two neuron layers. Each lane keeps
// its last captured value; ready_out is high while every lane has delivered
// in the current round. new_round is the input layer's start-of-round strobe.
// Optional build macro: INTERLAYER_HOLD_EN (see lane_capture).
module interlayer_collect
    import interlayer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_round,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             ready1,
    input  logic             ready2,
    input  logic             ready3,
    input  logic             ready4,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             ready_out
);

    logic [WIDTH-1:0]     din  [NUM_LANES];
    logic [WIDTH-1:0]     dout [NUM_LANES];
    logic [NUM_LANES-1:0] strobe;
    logic [NUM_LANES-1:0] done_next;

    assign din[0] = in1;
    assign din[1] = in2;
    assign din[2] = in3;
    assign din[3] = in4;
    assign strobe = {ready4, ready3, ready2, ready1};
    assign out1   = dout[0];
    assign out2   = dout[1];
    assign out3   = dout[2];
    assign out4   = dout[3];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_capture #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .new_round (new_round),
            .strobe    (strobe[i]),
            .din       (din[i]),
            .dout      (dout[i]),
            .done_next (done_next[i])
        );
    end

    // ready_out tracks the flags being written this edge, so it is a level
    // that appears with the last delivery and drops with the clearing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_out <= 1'b0;
        end else begin
            ready_out <= &done_next;
        end
    end

endmodule

// File: tb/tb_interlayer_collect.sv
// Self-checking bench for interlayer_collect: directed test-plan steps, then
// randomized rounds, all compared against a round/delivery model.
module tb_interlayer_collect;
    import interlayer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_round = 1'b0;
    lane_t       in_v  [4];
    logic [3:0]  rdy = 4'h0;
    lane_t       out_v [4];
    logic        ready_out;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    lane_t m_val  [4];
    bit    m_got  [4];
    bit    m_ready;

    always #5 clk = ~clk;

    interlayer_collect #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .new_round (new_round),
        .in1       (in_v[0]),
        .in2       (in_v[1]),
        .in3       (in_v[2]),
        .in4       (in_v[3]),
        .ready1    (rdy[0]),
        .ready2    (rdy[1]),
        .ready3    (rdy[2]),
        .ready4    (rdy[3]),
        .out1      (out_v[0]),
        .out2      (out_v[1]),
        .out3      (out_v[2]),
        .out4      (out_v[3]),
        .ready_out (ready_out)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the round rules, then
    // compare every output 1 time unit after the edge.
    task automatic cycle(input bit r, input bit nw, input bit [3:0] rd, input bit [31:0] d);
        bit hold;
        rst = r;
        new_round = nw;
        rdy = rd;
        for (int k = 0; k < 4; k++) in_v[k] = d[8*k +: 8];
        @(posedge clk);
`ifdef INTERLAYER_HOLD_EN
        hold = 1'b1;
`else
        hold = 1'b0;
`endif
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_val[k] = 8'h00;
                m_got[k] = 1'b0;
            end
        end else begin
            if (nw) for (int k = 0; k < 4; k++) m_got[k] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (rd[k]) begin
                    if (!(hold && m_got[k])) m_val[k] = d[8*k +: 8];
                    m_got[k] = 1'b1;
                end
            end
        end
        m_ready = m_got[0] && m_got[1] && m_got[2] && m_got[3];
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("out%0d", k + 1), out_v[k], m_val[k]);
        chk("ready_out", {7'd0, ready_out}, {7'd0, m_ready});
    endtask

    initial begin
        bit [31:0] d;
        for (int k = 0; k < 4; k++) in_v[k] = 8'h00;

        // reset with all inputs active
        cycle(1, 0, 4'hF, 32'hFFFF_FFFF);
        cycle(1, 0, 4'hF, 32'hFFFF_FFFF);
        chk("reset_out1", out_v[0], 8'h00);
        chk("reset_ready", {7'd0, ready_out}, 8'h00);

        // staggered delivery
        cycle(0, 1, 4'h0, 32'h0);
        cycle(0, 0, 4'h1, 32'h0000_0011);
        cycle(0, 0, 4'h2, 32'h0000_2200);
        cycle(0, 0, 4'h4, 32'h0033_0000);
        chk("stagger_not_ready", {7'd0, ready_out}, 8'h00);
        cycle(0, 0, 4'h8, 32'h4400_0000);
        chk("stagger_ready", {7'd0, ready_out}, 8'h01);
        cycle(0, 0, 4'h0, 32'h0);
        chk("stagger_held", {7'd0, ready_out}, 8'h01);
        chk("stagger_out4", out_v[3], 8'h44);

        // round restart keeps values
        cycle(0, 1, 4'h0, 32'h0);
        chk("restart_ready", {7'd0, ready_out}, 8'h00);
        chk("restart_out2", out_v[1], 8'h22);

        // new + ready3 together
        cycle(0, 1, 4'h4, 32'h005A_0000);
        chk("new_ready3_out3", out_v[2], 8'h5A);
        chk("new_ready3_ready", {7'd0, ready_out}, 8'h00);
        cycle(0, 0, 4'hB, 32'h0400_0201);
        chk("complete_ready", {7'd0, ready_out}, 8'h01);

        // new + last missing lane: stays not ready
        cycle(0, 1, 4'h7, 32'h0001_0203);
        cycle(0, 1, 4'h8, 32'h0900_0000);
        chk("new_last_lane", {7'd0, ready_out}, 8'h00);

        // all four in one cycle
        cycle(0, 1, 4'hF, 32'hA1B2_C3D4);
        chk("all_four", {7'd0, ready_out}, 8'h01);

        // overwrite in same round
        cycle(0, 1, 4'h0, 32'h0);
        cycle(0, 0, 4'h2, 32'h0000_1000);
        cycle(0, 0, 4'h2, 32'h0000_2000);
`ifdef INTERLAYER_HOLD_EN
        chk("overwrite_out2", out_v[1], 8'h10);
`else
        chk("overwrite_out2", out_v[1], 8'h20);
`endif

        // reset mid-round
        cycle(0, 1, 4'h3, 32'h0000_7766);
        cycle(1, 0, 4'h0, 32'h0);
        chk("midrst_out1", out_v[0], 8'h00);
        cycle(0, 0, 4'h4, 32'h0055_0000);
        cycle(0, 0, 4'h8, 32'h6600_0000);
        chk("midrst_ready", {7'd0, ready_out}, 8'h00);

        // random traffic, with phases of rare, frequent and continuous new
        for (int i = 0; i < 600; i++) begin
            bit nw, r;
            bit [3:0] rd;
            d  = $urandom;
            rd = 4'($urandom);
            if (i < 200)      nw = ($urandom_range(0, 9) == 0);
            else if (i < 400) nw = ($urandom_range(0, 2) == 0);
            else if (i < 500) nw = 1'b1;
            else              nw = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 49) == 0);
            cycle(r, nw, rd, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
